// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single-ported data memory between the load path of the load/store
// unit (reads) and the store-buffer drain (writes). Loads win by default; after
// STARVE_LIMIT consecutive denied store-request cycles the next store is forced
// through ahead of any load. One dmem access is granted per cycle.
//
// Optional feature: define DMEM_ARB_PERF_EN to build the two 32-bit saturating
// stall counters. When it is undefined the counter ports read 0 and no counter
// flops exist.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_ld_req/addr     load request and address
//   o_ld_gnt          load issued to dmem this cycle (combinational)
//   o_ld_rvalid/rdata load response, one cycle after the grant
//   i_st_req/addr/data retired store at the head of the store buffer
//   o_st_ack          store written this cycle (combinational), pops the buffer
//   i_kill            pipeline flush: cancels load grant / load response
//   o_dmem_*          dmem macro interface (en, we, addr, wdata)
//   i_dmem_rdata      dmem read data, 1-cycle latency
//   o_ld_stall_cnt    cycles a load request was denied (perf)
//   o_st_stall_cnt    cycles a store request was denied (perf)
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_ld_req,
   input  logic [ADDR_W-1:0] i_ld_addr,
   output logic              o_ld_gnt,
   output logic              o_ld_rvalid,
   output logic [DATA_W-1:0] o_ld_rdata,
   input  logic              i_st_req,
   input  logic [ADDR_W-1:0] i_st_addr,
   input  logic [DATA_W-1:0] i_st_data,
   output logic              o_st_ack,
   input  logic              i_kill,
   output logic              o_dmem_en,
   output logic              o_dmem_we,
   output logic [ADDR_W-1:0] o_dmem_addr,
   output logic [DATA_W-1:0] o_dmem_wdata,
   input  logic [DATA_W-1:0] i_dmem_rdata,
   output logic [31:0]       o_ld_stall_cnt,
   output logic [31:0]       o_st_stall_cnt
);

   typedef enum logic {
      S_LDPRI   = 1'b0,
      S_STFORCE = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic [CNT_W-1:0]  w_starve_cnt_nxt;
   logic              r_ld_rvalid;
   logic [DATA_W-1:0] r_ld_rdata;
   logic              w_ld_req_eff;
   logic              w_ld_gnt;
   logic              w_st_ack;

   // A load request seen during a flush is dropped, which lets a waiting
   // store use the slot.
   assign w_ld_req_eff = i_ld_req & ~i_kill;

   // Grant selection, starvation counting and next state.
   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      w_ld_gnt         = 1'b0;
      w_st_ack         = 1'b0;
      w_state_nxt      = r_state;
      w_starve_cnt_nxt = r_starve_cnt;

      // No grants while reset is held, so nothing is acked mid-reset.
      if (rst_n) begin
         unique case (r_state)
            S_LDPRI: begin
               if (w_ld_req_eff)  w_ld_gnt = 1'b1;
               else if (i_st_req) w_st_ack = 1'b1;
            end
            S_STFORCE: begin
               // Forced store slot; a withdrawn store hands it back to loads.
               if (i_st_req)          w_st_ack = 1'b1;
               else if (w_ld_req_eff) w_ld_gnt = 1'b1;
               w_state_nxt = S_LDPRI;
            end
            default: w_state_nxt = S_LDPRI;
         endcase
      end

      if (i_st_req && !w_st_ack) begin
         if (r_starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
            w_starve_cnt_nxt = '0;
            w_state_nxt      = S_STFORCE;
         end else begin
            w_starve_cnt_nxt = r_starve_cnt + 1'b1;
         end
      end else begin
         w_starve_cnt_nxt = '0;
      end
   end

   assign o_ld_gnt     = w_ld_gnt;
   assign o_st_ack     = w_st_ack;
   assign o_dmem_en    = w_ld_gnt | w_st_ack;
   assign o_dmem_we    = w_st_ack;
   assign o_dmem_addr  = w_st_ack ? i_st_addr :
                         w_ld_gnt ? i_ld_addr : '0;
   assign o_dmem_wdata = w_st_ack ? i_st_data : '0;

   // The dmem data arrives in the response cycle, so it is passed straight
   // through then and captured so that o_ld_rdata holds it afterwards.
   assign o_ld_rvalid  = r_ld_rvalid & ~i_kill;
   assign o_ld_rdata   = o_ld_rvalid ? i_dmem_rdata : r_ld_rdata;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_state      <= S_LDPRI;
         r_starve_cnt <= '0;
         r_ld_rvalid  <= 1'b0;
         r_ld_rdata   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_cnt_nxt;
         r_ld_rvalid  <= w_ld_gnt;
         if (o_ld_rvalid) r_ld_rdata <= i_dmem_rdata;
      end
   end

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] r_ld_stall_cnt;
   logic [31:0] r_st_stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ld_stall_cnt <= '0;
         r_st_stall_cnt <= '0;
      end else begin
         if (i_ld_req && !w_ld_gnt && (r_ld_stall_cnt != 32'hFFFF_FFFF))
            r_ld_stall_cnt <= r_ld_stall_cnt + 32'd1;
         if (i_st_req && !w_st_ack && (r_st_stall_cnt != 32'hFFFF_FFFF))
            r_st_stall_cnt <= r_st_stall_cnt + 32'd1;
      end
   end

   assign o_ld_stall_cnt = r_ld_stall_cnt;
   assign o_st_stall_cnt = r_st_stall_cnt;
`else
   assign o_ld_stall_cnt = 32'd0;
   assign o_st_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed scenarios followed by a randomized run checked against a
// cycle-level reference model of the arbitration rules (load priority,
// forced store after STARVE_LIMIT consecutive denials, kill, 1-cycle response).
// Perf counter expectations depend on DMEM_ARB_PERF_EN.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;
`ifdef DMEM_ARB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_ld_req;
   logic [ADDR_W-1:0] i_ld_addr;
   logic              o_ld_gnt;
   logic              o_ld_rvalid;
   logic [DATA_W-1:0] o_ld_rdata;
   logic              i_st_req;
   logic [ADDR_W-1:0] i_st_addr;
   logic [DATA_W-1:0] i_st_data;
   logic              o_st_ack;
   logic              i_kill;
   logic              o_dmem_en;
   logic              o_dmem_we;
   logic [ADDR_W-1:0] o_dmem_addr;
   logic [DATA_W-1:0] o_dmem_wdata;
   logic [DATA_W-1:0] i_dmem_rdata = '0;
   logic [31:0]       o_ld_stall_cnt;
   logic [31:0]       o_st_stall_cnt;

   int total = 0;
   int bad   = 0;

   // Value the dmem model presents one cycle after each edge.
   logic [DATA_W-1:0] rd_src = '0;

   dmem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr), .o_ld_gnt(o_ld_gnt),
      .o_ld_rvalid(o_ld_rvalid), .o_ld_rdata(o_ld_rdata),
      .i_st_req(i_st_req), .i_st_addr(i_st_addr), .i_st_data(i_st_data),
      .o_st_ack(o_st_ack), .i_kill(i_kill),
      .o_dmem_en(o_dmem_en), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
      .o_dmem_wdata(o_dmem_wdata), .i_dmem_rdata(i_dmem_rdata),
      .o_ld_stall_cnt(o_ld_stall_cnt), .o_st_stall_cnt(o_st_stall_cnt)
   );

   always #5 clk = ~clk;

   // Synchronous dmem read port: data appears the cycle after the access.
   always @(posedge clk) i_dmem_rdata <= rd_src;

   task automatic set_in(input logic ld, input logic [31:0] la, input logic st,
                         input logic [31:0] sa, input logic [31:0] sd,
                         input logic k);
      i_ld_req  = ld;
      i_ld_addr = la;
      i_st_req  = st;
      i_st_addr = sa;
      i_st_data = sd;
      i_kill    = k;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++;
      if ({o_ld_rvalid, o_ld_gnt, o_st_ack, o_dmem_en} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_ctrl: got rvalid/gnt/ack/en=%b want 0000",
                  {o_ld_rvalid, o_ld_gnt, o_st_ack, o_dmem_en});
      end
      total++;
      if ({o_ld_rdata, o_dmem_addr, o_dmem_wdata} !== '0) begin
         bad++;
         $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0",
                  o_ld_rdata, o_dmem_addr, o_dmem_wdata);
      end
      total++;
      if ({o_ld_stall_cnt, o_st_stall_cnt} !== 64'd0) begin
         bad++;
         $display("FAIL reset_perf: ld=%0d st=%0d want 0", o_ld_stall_cnt, o_st_stall_cnt);
      end
   endtask

   task automatic test_load();
      do_reset();
      set_in(1, 32'h100, 0, 0, 0, 0);
      rd_src = 32'hDEAD_BEEF;
      #1;
      total++;
      if ({o_ld_gnt, o_st_ack, o_dmem_en, o_dmem_we} !== 4'b1010 || o_dmem_addr !== 32'h100) begin
         bad++;
         $display("FAIL load_grant: gnt/ack/en/we=%b addr=%h want 1010 addr=100",
                  {o_ld_gnt, o_st_ack, o_dmem_en, o_dmem_we}, o_dmem_addr);
      end
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0);
      rd_src = 32'h0BAD_0BAD;
      #1;
      total++;
      if (o_ld_rvalid !== 1'b1 || o_ld_rdata !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL load_resp: rvalid=%b rdata=%h want 1 deadbeef", o_ld_rvalid, o_ld_rdata);
      end
      @(negedge clk);
      #1;
      total++;
      if (o_ld_rvalid !== 1'b0 || o_ld_rdata !== 32'hDEAD_BEEF) begin
         bad++;
         $display("FAIL load_hold: rvalid=%b rdata=%h want 0 deadbeef", o_ld_rvalid, o_ld_rdata);
      end
   endtask

   task automatic test_store();
      @(negedge clk);
      set_in(0, 0, 1, 32'h200, 32'h1234_5678, 0);
      #1;
      total++;
      if ({o_ld_gnt, o_st_ack, o_dmem_en, o_dmem_we} !== 4'b0111 ||
          o_dmem_addr !== 32'h200 || o_dmem_wdata !== 32'h1234_5678) begin
         bad++;
         $display("FAIL store_grant: gnt/ack/en/we=%b addr=%h wdata=%h want 0111 200 12345678",
                  {o_ld_gnt, o_st_ack, o_dmem_en, o_dmem_we}, o_dmem_addr, o_dmem_wdata);
      end
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0);
   endtask

   // Both requesters held high: four loads, one forced store, repeating.
   task automatic test_starve();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         set_in(1, 32'h40 + c, 1, 32'h80, 32'hCAFE_0000 + c, 0);
         #1;
         total++;
         if (o_ld_gnt !== (c % 5 != 4) || o_st_ack !== (c % 5 == 4)) begin
            bad++;
            $display("FAIL starve_c%0d: gnt=%b ack=%b want %b %b", c, o_ld_gnt, o_st_ack,
                     c % 5 != 4, c % 5 == 4);
         end
         @(negedge clk);
      end
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      total++;
      if (o_st_stall_cnt !== (PERF ? 32'd8 : 32'd0) || o_ld_stall_cnt !== (PERF ? 32'd2 : 32'd0)) begin
         bad++;
         $display("FAIL starve_perf: st=%0d ld=%0d want %0d %0d", o_st_stall_cnt, o_ld_stall_cnt,
                  PERF ? 8 : 0, PERF ? 2 : 0);
      end
   endtask

   task automatic test_kill();
      do_reset();
      set_in(1, 32'h300, 0, 0, 0, 0);
      rd_src = 32'h5555_AAAA;
      #1;
      total++;
      if (o_ld_gnt !== 1'b1) begin
         bad++;
         $display("FAIL kill_pre_gnt: gnt=%b want 1", o_ld_gnt);
      end
      @(negedge clk);
      set_in(1, 32'h304, 1, 32'h400, 32'h0000_BEEF, 1);
      #1;
      total++;
      if ({o_ld_rvalid, o_ld_gnt, o_st_ack, o_dmem_we} !== 4'b0011 || o_dmem_addr !== 32'h400) begin
         bad++;
         $display("FAIL kill_cycle: rvalid/gnt/ack/we=%b addr=%h want 0011 400",
                  {o_ld_rvalid, o_ld_gnt, o_st_ack, o_dmem_we}, o_dmem_addr);
      end
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      total++;
      if (o_ld_rvalid !== 1'b0 || o_ld_rdata !== 32'd0) begin
         bad++;
         $display("FAIL kill_after: rvalid=%b rdata=%h want 0 0", o_ld_rvalid, o_ld_rdata);
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         set_in(1, 32'h10, 1, 32'h20, 32'h30, 0);
         @(negedge clk);
      end
      // Force begins now, but the store is withdrawn.
      set_in(1, 32'h14, 0, 0, 0, 0);
      #1;
      total++;
      if (o_ld_gnt !== 1'b1 || o_st_ack !== 1'b0 || o_dmem_addr !== 32'h14) begin
         bad++;
         $display("FAIL withdraw: gnt=%b ack=%b addr=%h want 1 0 14", o_ld_gnt, o_st_ack, o_dmem_addr);
      end
      @(negedge clk);
      // Back in load priority with a clear counter: four loads before a store.
      for (int c = 0; c < 5; c++) begin
         set_in(1, 32'h18, 1, 32'h20, 32'h30, 0);
         #1;
         total++;
         if (o_ld_gnt !== (c != 4) || o_st_ack !== (c == 4)) begin
            bad++;
            $display("FAIL withdraw_after_c%0d: gnt=%b ack=%b want %b %b", c, o_ld_gnt, o_st_ack,
                     c != 4, c == 4);
         end
         @(negedge clk);
      end
      set_in(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_mid_reset();
      do_reset();
      set_in(1, 32'h500, 0, 0, 0, 0);
      rd_src = 32'h7777_7777;
      @(negedge clk);
      rst_n = 1'b0;
      set_in(0, 0, 1, 32'h600, 32'h1, 0);
      #1;
      total++;
      if (o_st_ack !== 1'b0 || o_dmem_en !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_ack: ack=%b en=%b want 0 0", o_st_ack, o_dmem_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);
      #1;
      total++;
      if (o_ld_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_rvalid: rvalid=%b want 0", o_ld_rvalid);
      end
   endtask

   // Randomized traffic against the reference model. The model tracks the
   // number of consecutive cycles a store has waited; once that reaches
   // STARVE_LIMIT the store beats any load.
   task automatic test_random();
      int          waited;
      bit          pend;
      logic [31:0] pend_data, hold_data;
      int          ld_stall, st_stall;
      bit          ld_hold, st_hold;
      bit          ld_eff, st_win, ld_win, e_rvalid;
      logic [31:0] e_rdata, e_addr, e_wdata;

      do_reset();
      waited = 0; pend = 0; pend_data = 0; hold_data = 0;
      ld_stall = 0; st_stall = 0; ld_hold = 0; st_hold = 0;
      for (int c = 0; c < 600; c++) begin
         if (!ld_hold) begin
            i_ld_req  = ($urandom % 3) != 0;
            i_ld_addr = $urandom;
         end
         if (!st_hold) begin
            i_st_req  = ($urandom % 2) != 0;
            i_st_addr = $urandom;
            i_st_data = $urandom;
         end
         i_kill = ($urandom % 8) == 0;
         rd_src = $urandom;
         #1;
         ld_eff   = i_ld_req && !i_kill;
         st_win   = i_st_req && (!ld_eff || waited >= STARVE_LIMIT);
         ld_win   = ld_eff && !st_win;
         e_rvalid = pend && !i_kill;
         e_rdata  = e_rvalid ? pend_data : hold_data;
         e_addr   = st_win ? i_st_addr : (ld_win ? i_ld_addr : 32'd0);
         e_wdata  = st_win ? i_st_data : 32'd0;

         total++;
         if ({o_ld_gnt, o_st_ack, o_dmem_en, o_dmem_we} !== {ld_win, st_win, ld_win | st_win, st_win}) begin
            bad++;
            $display("FAIL rand_ctrl_c%0d: gnt/ack/en/we=%b want %b", c,
                     {o_ld_gnt, o_st_ack, o_dmem_en, o_dmem_we},
                     {ld_win, st_win, ld_win | st_win, st_win});
         end
         total++;
         if (o_dmem_addr !== e_addr || o_dmem_wdata !== e_wdata) begin
            bad++;
            $display("FAIL rand_bus_c%0d: addr=%h wdata=%h want %h %h", c,
                     o_dmem_addr, o_dmem_wdata, e_addr, e_wdata);
         end
         total++;
         if (o_ld_rvalid !== e_rvalid || o_ld_rdata !== e_rdata) begin
            bad++;
            $display("FAIL rand_resp_c%0d: rvalid=%b rdata=%h want %b %h", c,
                     o_ld_rvalid, o_ld_rdata, e_rvalid, e_rdata);
         end
         total++;
         if (o_ld_stall_cnt !== (PERF ? 32'(ld_stall) : 32'd0) ||
             o_st_stall_cnt !== (PERF ? 32'(st_stall) : 32'd0)) begin
            bad++;
            $display("FAIL rand_perf_c%0d: ld=%0d st=%0d want %0d %0d", c,
                     o_ld_stall_cnt, o_st_stall_cnt, PERF ? ld_stall : 0, PERF ? st_stall : 0);
         end

         ld_hold = i_ld_req && !ld_win;
         st_hold = i_st_req && !st_win;
         @(posedge clk);
         if (e_rvalid) hold_data = pend_data;
         pend      = ld_win;
         pend_data = rd_src;
         waited    = (i_st_req && !st_win) ? waited + 1 : 0;
         if (i_ld_req && !ld_win) ld_stall++;
         if (i_st_req && !st_win) st_stall++;
         @(negedge clk);
      end
      set_in(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      test_reset();
      test_load();
      test_store();
      test_starve();
      test_kill();
      test_withdraw();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the load path of the load/store execution unit (reads) and the store-buffer drain of retired stores (writes).
- Loads win by default for latency. A starvation counter forces a store slot after STARVE_LIMIT consecutive denials.
- Sits between the load/store unit, the store buffer and the dmem macro. It replaces the ad-hoc dmem occupy signalling with an explicit grant/ack handshake.

Parameters:
- ADDR_W, 32, dmem address width in bits.
- DATA_W, 32, dmem data width in bits.
- STARVE_LIMIT, 4, consecutive denied store-request cycles before a store is forced. Legal range 1..15.
- CNT_W, 4, width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_ld_req  in  1  load requests a dmem read this cycle.
- i_ld_addr  in  ADDR_W  load address.
- o_ld_gnt  out  1  read issued to dmem this cycle (combinational).
- o_ld_rvalid  out  1  read data valid (one cycle after grant).
- o_ld_rdata  out  DATA_W  read data.
- i_st_req  in  1  store buffer has a retired store to drain.
- i_st_addr  in  ADDR_W  store address.
- i_st_data  in  DATA_W  store data.
- o_st_ack  out  1  store written this cycle (combinational); store buffer pops its head.
- i_kill  in  1  pipeline flush; cancels a load response in flight.
- o_dmem_en  out  1  dmem access enable.
- o_dmem_we  out  1  dmem write enable.
- o_dmem_addr  out  ADDR_W  dmem address.
- o_dmem_wdata  out  DATA_W  dmem write data.
- i_dmem_rdata  in  DATA_W  dmem read data, synchronous, 1-cycle latency.
- o_ld_stall_cnt  out  32  perf counter (see Optional Feature).
- o_st_stall_cnt  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset values: o_ld_rvalid=0, o_ld_rdata=0, starvation counter=0, FSM in S_LDPRI, perf counters=0. Combinational outputs follow from these values and the current inputs.
- FSM states:
  - S_LDPRI: loads have priority.
  - S_STFORCE: the next store request is granted regardless of any load request.
- S_LDPRI grant rules:
  - i_ld_req=1: grant load (o_ld_gnt=1, o_dmem_en=1, o_dmem_we=0, o_dmem_addr=i_ld_addr).
  - Else if i_st_req=1: grant store (o_st_ack=1, o_dmem_en=1, o_dmem_we=1, address and data from the store port).
  - Else idle: o_dmem_en=0.
- Starvation counter:
  - Increments in any cycle where i_st_req=1 and o_st_ack=0.
  - Clears to 0 on any o_st_ack, and in any cycle with i_st_req=0.
  - When the increment would reach STARVE_LIMIT, the counter clears and the FSM moves to S_STFORCE next cycle.
- S_STFORCE:
  - i_st_req=1: grant store; o_ld_gnt=0 even if i_ld_req=1. Return to S_LDPRI.
  - i_st_req=0 (store withdrawn): grant load normally and return to S_LDPRI.
- Exactly one grant per cycle. o_ld_gnt and o_st_ack are never both 1.
- o_dmem_addr and o_dmem_wdata are 0 when o_dmem_en=0.
- Requesters hold request, address and data stable until granted.
- Load response:
  - The cycle after o_ld_gnt: o_ld_rvalid=1 and o_ld_rdata is registered from i_dmem_rdata.
  - Latency from grant to data is fixed at 1 cycle. There is no back-pressure on the response.
  - o_ld_rvalid deasserts the following cycle unless a new grant was made.
  - o_ld_rdata holds its last value when o_ld_rvalid=0.
- Back-to-back loads are granted every cycle.
- i_kill:
  - i_kill=1 in the grant cycle or the response cycle forces o_ld_rvalid=0 for that load.
  - i_kill does not affect stores (they are architecturally committed), the FSM or the starvation counter.
  - A load request present in the kill cycle is not granted.
- Same address, load and store requested in the same cycle: no forwarding here. The load reads memory before the store is written, and the store buffer is responsible for hit forwarding.
- Reset mid-operation: the pending response is dropped (o_ld_rvalid=0 next cycle). No ack is generated.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined:
  - o_ld_stall_cnt increments each cycle i_ld_req=1 and o_ld_gnt=0.
  - o_st_stall_cnt increments each cycle i_st_req=1 and o_st_ack=0.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset, then i_ld_req=1 with addr 0x100 for 1 cycle, dmem returns 0xDEADBEEF -> o_ld_gnt=1 in cycle 0; o_ld_rvalid=1, o_ld_rdata=0xDEADBEEF in cycle 1; o_ld_rvalid=0 in cycle 2.
- i_st_req=1 (addr 0x200, data 0x12345678), no load -> o_st_ack=1 same cycle; o_dmem_we=1, o_dmem_addr=0x200, o_dmem_wdata=0x12345678.
- i_ld_req and i_st_req both held high continuously, STARVE_LIMIT=4 -> 4 load grants, then 1 store ack in cycle 4 with o_ld_gnt=0, then loads resume; the pattern repeats every 5 cycles.
- Load granted in cycle 0, i_kill=1 in cycle 1 -> o_ld_rvalid=0 in cycle 1. A store acked in cycle 1 still completes with o_st_ack=1.
- Store withdrawn while in S_STFORCE (i_st_req drops the cycle the force begins) -> load granted that cycle; FSM back in S_LDPRI; counter=0.
- With DMEM_ARB_PERF_EN, run the 3rd scenario for 10 cycles -> o_st_stall_cnt=8, o_ld_stall_cnt=2. Without the macro, both read 0.
